// File: rtl/usb_in_ep_sched.sv
// usb_in_ep_sched: per-endpoint IN packet scheduler. Holds one armed packet
// descriptor per IN endpoint, feeds the IN protocol engine with has-data,
// data-done and packet bytes fetched from the packet SRAM, and retires
// descriptors on ACK (or on data completion for isochronous endpoints).
module usb_in_ep_sched #(
  parameter int NumInEps         = 12,
  parameter int MaxInPktSizeByte = 32,
  parameter int NumBuffers       = 32,
  parameter int SramAw           = 10
) (
  input  logic                                  clk_48mhz_i,
  input  logic                                  rst_ni,
  input  logic                                  link_reset_i,
  input  logic                                  cfg_wr_i,
  input  logic [3:0]                            cfg_ep_i,
  input  logic [$clog2(NumBuffers)-1:0]         cfg_buf_i,
  input  logic [$clog2(MaxInPktSizeByte):0]     cfg_size_i,
  input  logic                                  cfg_rdy_i,
  output logic                                  cfg_err_o,
  output logic [NumInEps-1:0]                   sent_o,
  input  logic [NumInEps-1:0]                   in_ep_iso_i,
  input  logic [3:0]                            in_ep_current_i,
  input  logic                                  in_ep_newpkt_i,
  input  logic                                  in_ep_acked_i,
  input  logic                                  in_ep_rollback_i,
  input  logic                                  in_ep_data_get_i,
  input  logic [$clog2(MaxInPktSizeByte)-1:0]   in_ep_get_addr_i,
  output logic [NumInEps-1:0]                   in_ep_has_data_o,
  output logic [NumInEps-1:0]                   in_ep_data_done_o,
  output logic [7:0]                            in_ep_data_o,
  output logic                                  mem_req_o,
  output logic [SramAw-1:0]                     mem_addr_o,
  input  logic [31:0]                           mem_rdata_i
);

  localparam int PktW = $clog2(MaxInPktSizeByte);
  localparam int BufW = $clog2(NumBuffers);
  localparam logic [PktW:0] MaxSize = (PktW+1)'(MaxInPktSizeByte);

  typedef enum logic {StIdle, StActive} state_e;

  state_e                state_q, state_d;
  logic [3:0]            ep_q, ep_d;
  logic [NumInEps-1:0]   rdy_q;
  logic [BufW-1:0]       buf_q  [NumInEps];
  logic [PktW:0]         size_q [NumInEps];
  logic [1:0]            lane_q;
  logic                  cfg_err_q;
  logic [NumInEps-1:0]   sent_q;

  logic [NumInEps-1:0]   ep_q_oh, cur_oh, cfg_oh;
  logic [BufW-1:0]       buf_cur;
  logic                  iso_done, retire;
  logic                  cfg_bad, cfg_accept, cfg_reject;
  logic                  unused_data_get;

  // The engine drives byte fetches purely by address; the get strobe is not needed.
  assign unused_data_get = in_ep_data_get_i;

  // Endpoint decodes, current-endpoint buffer lookup and data-done flags.
  always_comb begin
    ep_q_oh           = '0;
    cur_oh            = '0;
    cfg_oh            = '0;
    buf_cur           = '0;
    in_ep_data_done_o = '0;
    for (int i = 0; i < NumInEps; i++) begin
      ep_q_oh[i] = (ep_q == 4'(i));
      cur_oh[i]  = (in_ep_current_i == 4'(i));
      cfg_oh[i]  = (cfg_ep_i == 4'(i));
      if (cur_oh[i]) begin
        buf_cur = buf_q[i];
      end
      in_ep_data_done_o[i] = cur_oh[i] & ({1'b0, in_ep_get_addr_i} >= size_q[i]);
    end
  end

  // An isochronous packet retires as soon as the engine has consumed all its bytes.
  assign iso_done = |(ep_q_oh & in_ep_iso_i & rdy_q & in_ep_data_done_o);

  // Config write validation: bad endpoint, oversize, or endpoint in use by the engine.
  assign cfg_bad = ({1'b0, cfg_ep_i} >= 5'(NumInEps)) |
                   (cfg_size_i > MaxSize) |
                   ((state_q == StActive) & (cfg_ep_i == ep_q)) |
                   (in_ep_newpkt_i & (cfg_ep_i == in_ep_current_i));
  assign cfg_accept = cfg_wr_i & ~link_reset_i & ~cfg_bad;
  assign cfg_reject = cfg_wr_i & ~link_reset_i & cfg_bad;

  // FSM state register.
  always_ff @(posedge clk_48mhz_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ep_q    <= '0;
    end else begin
      state_q <= state_d;
      ep_q    <= ep_d;
    end
  end

  // FSM next state: link reset, then newpkt, then ack/rollback/iso completion.
  always_comb begin
    state_d = state_q;
    ep_d    = ep_q;
    if (link_reset_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_ep_newpkt_i) begin
            state_d = StActive;
            ep_d    = in_ep_current_i;
          end
        end
        StActive: begin
          if (in_ep_newpkt_i) begin
            ep_d = in_ep_current_i;
          end else if (in_ep_acked_i | in_ep_rollback_i | iso_done) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: retirement of the active descriptor; rollback keeps it armed.
  always_comb begin
    retire = 1'b0;
    if ((state_q == StActive) && !link_reset_i && !in_ep_newpkt_i) begin
      retire = in_ep_acked_i | (~in_ep_rollback_i & iso_done);
    end
  end

  // Descriptor table, byte lane and registered status pulses.
  always_ff @(posedge clk_48mhz_i) begin
    if (!rst_ni) begin
      rdy_q     <= '0;
      lane_q    <= '0;
      cfg_err_q <= 1'b0;
      sent_q    <= '0;
      for (int i = 0; i < NumInEps; i++) begin
        buf_q[i]  <= '0;
        size_q[i] <= '0;
      end
    end else begin
      lane_q    <= in_ep_get_addr_i[1:0];
      cfg_err_q <= cfg_reject;
      sent_q    <= retire ? ep_q_oh : '0;
      if (link_reset_i) begin
        rdy_q <= '0;
      end else begin
        for (int i = 0; i < NumInEps; i++) begin
          if (cfg_accept && cfg_oh[i]) begin
            rdy_q[i]  <= cfg_rdy_i;
            buf_q[i]  <= cfg_buf_i;
            size_q[i] <= cfg_size_i;
          end
          if (retire && ep_q_oh[i]) begin
            rdy_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign cfg_err_o        = cfg_err_q;
  assign sent_o           = sent_q;
  assign in_ep_has_data_o = rdy_q;
  assign mem_req_o        = (state_q == StActive) | in_ep_newpkt_i;
  assign mem_addr_o       = SramAw'(buf_cur) * SramAw'(MaxInPktSizeByte / 4) +
                            SramAw'(in_ep_get_addr_i[PktW-1:2]);
  assign in_ep_data_o     = mem_rdata_i[{lane_q, 3'b000} +: 8];

endmodule
